// File: rtl/sha2_compress_core.sv
`default_nettype none
// ============================================================================
//  Module      : sha2_compress_core
//  Description : Iterative SHA-256 / SHA-512 compression, one round per clock,
//                with a sliding 16-word message schedule and feed-forward add.
//  Revision    : 1.0
// ============================================================================
module sha2_compress_core #(
    parameter int WRD_SIZE   = 32,
    parameter int BLK_SIZE   = 8 * WRD_SIZE,
    parameter int MSG_SIZE   = 16 * WRD_SIZE,
    parameter int NUM_ROUNDS = (WRD_SIZE == 32) ? 64 : 80
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_start,
    input  logic [BLK_SIZE-1:0] i_pre_blck_hash,
    input  logic [MSG_SIZE-1:0] i_msg_blck,
    input  logic [WRD_SIZE-1:0] i_round_constant,
    output logic [6:0]          o_round_idx,
    output logic                o_ready,
    output logic                o_valid,
    output logic [BLK_SIZE-1:0] o_hash
);

    if (!((WRD_SIZE == 32 || WRD_SIZE == 64) &&
          BLK_SIZE == 8 * WRD_SIZE && MSG_SIZE == 16 * WRD_SIZE)) begin : g_bad_wrd_size
        $error("sha2_compress_core: WRD_SIZE must be 32 or 64 with derived sizes untouched");
    end

    localparam bit c_is256 = (WRD_SIZE == 32);

    localparam int c_bs0_r0 = c_is256 ? 2  : 28;
    localparam int c_bs0_r1 = c_is256 ? 13 : 34;
    localparam int c_bs0_r2 = c_is256 ? 22 : 39;
    localparam int c_bs1_r0 = c_is256 ? 6  : 14;
    localparam int c_bs1_r1 = c_is256 ? 11 : 18;
    localparam int c_bs1_r2 = c_is256 ? 25 : 41;
    localparam int c_ss0_r0 = c_is256 ? 7  : 1;
    localparam int c_ss0_r1 = c_is256 ? 18 : 8;
    localparam int c_ss0_sh = c_is256 ? 3  : 7;
    localparam int c_ss1_r0 = c_is256 ? 17 : 19;
    localparam int c_ss1_r1 = c_is256 ? 19 : 61;
    localparam int c_ss1_sh = c_is256 ? 10 : 6;

    localparam logic [6:0] c_last_round = 7'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    function automatic logic [WRD_SIZE-1:0] rotr(input logic [WRD_SIZE-1:0] x, input int n);
        return (x >> n) | (x << (WRD_SIZE - n));
    endfunction

    function automatic logic [WRD_SIZE-1:0] big_sigma0(input logic [WRD_SIZE-1:0] x);
        return rotr(x, c_bs0_r0) ^ rotr(x, c_bs0_r1) ^ rotr(x, c_bs0_r2);
    endfunction

    function automatic logic [WRD_SIZE-1:0] big_sigma1(input logic [WRD_SIZE-1:0] x);
        return rotr(x, c_bs1_r0) ^ rotr(x, c_bs1_r1) ^ rotr(x, c_bs1_r2);
    endfunction

    function automatic logic [WRD_SIZE-1:0] small_sigma0(input logic [WRD_SIZE-1:0] x);
        return rotr(x, c_ss0_r0) ^ rotr(x, c_ss0_r1) ^ (x >> c_ss0_sh);
    endfunction

    function automatic logic [WRD_SIZE-1:0] small_sigma1(input logic [WRD_SIZE-1:0] x);
        return rotr(x, c_ss1_r0) ^ rotr(x, c_ss1_r1) ^ (x >> c_ss1_sh);
    endfunction

    state_t              r_state;
    logic [6:0]          r_t;
    logic                r_ready;
    logic                r_valid;
    logic [BLK_SIZE-1:0] r_hash;
    logic [WRD_SIZE-1:0] r_wv    [8];   // working variables a..h
    logic [WRD_SIZE-1:0] r_hsave [8];   // chaining value kept for the feed-forward
    logic [WRD_SIZE-1:0] r_w     [16];  // schedule window, head is W[t]

    logic [WRD_SIZE-1:0] w_ch;
    logic [WRD_SIZE-1:0] w_maj;
    logic [WRD_SIZE-1:0] w_t1;
    logic [WRD_SIZE-1:0] w_t2;
    logic [WRD_SIZE-1:0] w_w_next;

    assign w_ch     = (r_wv[4] & r_wv[5]) ^ (~r_wv[4] & r_wv[6]);
    assign w_maj    = (r_wv[0] & r_wv[1]) ^ (r_wv[0] & r_wv[2]) ^ (r_wv[1] & r_wv[2]);
    assign w_t1     = r_wv[7] + big_sigma1(r_wv[4]) + w_ch + i_round_constant + r_w[0];
    assign w_t2     = big_sigma0(r_wv[0]) + w_maj;
    assign w_w_next = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_t     <= 7'd0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_hash  <= '0;
            for (int i = 0; i < 8; i++) begin
                r_wv[i]    <= '0;
                r_hsave[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                r_w[i] <= '0;
            end
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        for (int i = 0; i < 8; i++) begin
                            r_wv[i]    <= i_pre_blck_hash[BLK_SIZE-1-i*WRD_SIZE -: WRD_SIZE];
                            r_hsave[i] <= i_pre_blck_hash[BLK_SIZE-1-i*WRD_SIZE -: WRD_SIZE];
                        end
                        for (int i = 0; i < 16; i++) begin
                            r_w[i] <= i_msg_blck[MSG_SIZE-1-i*WRD_SIZE -: WRD_SIZE];
                        end
                        r_t     <= 7'd0;
                        r_ready <= 1'b0;
                        r_state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_wv[0] <= w_t1 + w_t2;
                    r_wv[1] <= r_wv[0];
                    r_wv[2] <= r_wv[1];
                    r_wv[3] <= r_wv[2];
                    r_wv[4] <= r_wv[3] + w_t1;
                    r_wv[5] <= r_wv[4];
                    r_wv[6] <= r_wv[5];
                    r_wv[7] <= r_wv[6];
                    for (int i = 0; i < 15; i++) begin
                        r_w[i] <= r_w[i+1];
                    end
                    r_w[15] <= w_w_next;
                    // Round index drops back to 0 on leaving ROUND so the ROM address idles at K[0].
                    if (r_t == c_last_round) begin
                        r_t     <= 7'd0;
                        r_state <= S_FINAL;
                    end else begin
                        r_t <= r_t + 7'd1;
                    end
                end
                S_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        r_hash[BLK_SIZE-1-i*WRD_SIZE -: WRD_SIZE] <= r_wv[i] + r_hsave[i];
                    end
                    r_valid <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_round_idx = r_t;
    assign o_ready     = r_ready;
    assign o_valid     = r_valid;
    assign o_hash      = r_hash;

endmodule
`default_nettype wire

// File: tb/tb_sha2_compress_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sha2_compress_core
//  Description : Bench for sha2_compress_core, SHA-256 and SHA-512 instances.
//  Revision    : 1.0
// ============================================================================
module tb_sha2_compress_core;

    localparam logic [63:0] K512 [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [255:0] IV256 =
        256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam logic [511:0] IV512 =
        512'h6a09e667f3bcc908_bb67ae8584caa73b_3c6ef372fe94f82b_a54ff53a5f1d36f1_510e527fade682d1_9b05688c2b3e6c1f_1f83d9abfb41bd6b_5be0cd19137e2179;
    localparam logic [255:0] DIG256_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] DIG256_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [511:0] DIG512_ABC =
        512'hddaf35a193617aba_cc417349ae204131_12e6fa4e89a97ea2_0a9eeee64b55d39a_2192992a274fc1a8_36ba3c23a3feebbd_454d4423643ce80e_2a9ac94fa54ca49f;
    localparam logic [511:0]  MSG256_ABC   = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0]  MSG256_EMPTY = {32'h80000000, 480'd0};
    localparam logic [1023:0] MSG512_ABC   = {64'h6162638000000000, 896'd0, 64'h18};

    logic clk;
    logic reset;

    logic          start256, ready256, valid256;
    logic [255:0]  h256, hash256;
    logic [511:0]  m256;
    logic [31:0]   rc256;
    logic [6:0]    idx256;

    logic          start512, ready512, valid512;
    logic [511:0]  h512, hash512;
    logic [1023:0] m512;
    logic [63:0]   rc512;
    logic [6:0]    idx512;

    int checks   = 0;
    int failures = 0;
    int vcnt256  = 0;
    int vcnt512  = 0;

    sha2_compress_core #(.WRD_SIZE(32)) dut256 (
        .clk              (clk),
        .reset            (reset),
        .i_start          (start256),
        .i_pre_blck_hash  (h256),
        .i_msg_blck       (m256),
        .i_round_constant (rc256),
        .o_round_idx      (idx256),
        .o_ready          (ready256),
        .o_valid          (valid256),
        .o_hash           (hash256)
    );

    sha2_compress_core #(.WRD_SIZE(64)) dut512 (
        .clk              (clk),
        .reset            (reset),
        .i_start          (start512),
        .i_pre_blck_hash  (h512),
        .i_msg_blck       (m512),
        .i_round_constant (rc512),
        .o_round_idx      (idx512),
        .o_ready          (ready512),
        .o_valid          (valid512),
        .o_hash           (hash512)
    );

    // External round-constant ROM; SHA-256 K values are the top halves of SHA-512's.
    always_comb begin
        rc256 = '0;
        rc512 = '0;
        if (idx256 < 7'd64) rc256 = K512[idx256][63:32];
        if (idx512 < 7'd80) rc512 = K512[idx512];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (valid256 === 1'b1) vcnt256 <= vcnt256 + 1;
        if (valid512 === 1'b1) vcnt512 <= vcnt512 + 1;
    end

    function automatic logic [63:0] wmask(input int w);
        return (w == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
    endfunction

    function automatic logic [63:0] rot(input int w, input logic [63:0] x, input int n);
        return ((x >> n) | (x << (w - n))) & wmask(w);
    endfunction

    function automatic logic [63:0] bs0(input int w, input logic [63:0] x);
        return (w == 32) ? (rot(w, x, 2) ^ rot(w, x, 13) ^ rot(w, x, 22))
                         : (rot(w, x, 28) ^ rot(w, x, 34) ^ rot(w, x, 39));
    endfunction

    function automatic logic [63:0] bs1(input int w, input logic [63:0] x);
        return (w == 32) ? (rot(w, x, 6) ^ rot(w, x, 11) ^ rot(w, x, 25))
                         : (rot(w, x, 14) ^ rot(w, x, 18) ^ rot(w, x, 41));
    endfunction

    function automatic logic [63:0] ss0(input int w, input logic [63:0] x);
        return (w == 32) ? (rot(w, x, 7) ^ rot(w, x, 18) ^ (x >> 3))
                         : (rot(w, x, 1) ^ rot(w, x, 8) ^ (x >> 7));
    endfunction

    function automatic logic [63:0] ss1(input int w, input logic [63:0] x);
        return (w == 32) ? (rot(w, x, 17) ^ rot(w, x, 19) ^ (x >> 10))
                         : (rot(w, x, 19) ^ rot(w, x, 61) ^ (x >> 6));
    endfunction

    // Textbook compression: full expanded schedule array, then the round loop.
    function automatic logic [511:0] ref_compress(input int w, input logic [511:0] hin,
                                                  input logic [1023:0] msg);
        logic [63:0]  m;
        logic [63:0]  ws [80];
        logic [63:0]  v  [8];
        logic [63:0]  hh [8];
        logic [63:0]  k, t1, t2;
        logic [511:0] r;
        int           rounds;
        m      = wmask(w);
        rounds = (w == 32) ? 64 : 80;
        for (int i = 0; i < 8; i++) begin
            hh[i] = 64'(hin >> ((7 - i) * w)) & m;
            v[i]  = hh[i];
        end
        for (int i = 0; i < 16; i++) ws[i] = 64'(msg >> ((15 - i) * w)) & m;
        for (int t = 16; t < 80; t++) begin
            ws[t] = (ss1(w, ws[t-2]) + ws[t-7] + ss0(w, ws[t-15]) + ws[t-16]) & m;
        end
        for (int t = 0; t < rounds; t++) begin
            k  = (w == 32) ? {32'd0, K512[t][63:32]} : K512[t];
            t1 = (v[7] + bs1(w, v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + ws[t]) & m;
            t2 = (bs0(w, v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]))) & m;
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = (v[4] + t1) & m;
            v[0] = (t1 + t2) & m;
        end
        r = '0;
        for (int i = 0; i < 8; i++) r = (r << w) | 512'((v[i] + hh[i]) & m);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues a start at the current negedge; returns at the negedge showing o_valid.
    task automatic run256(input string tag, input logic [255:0] h, input logic [511:0] m,
                          input bit hold, output logic [255:0] dig);
        int k;
        bit sweep_ok, ready_ok;
        h256 = h; m256 = m; start256 = 1'b1;
        @(negedge clk);
        if (!hold) start256 = 1'b0;
        k = 0;
        sweep_ok = (idx256 === 7'd0);
        ready_ok = (ready256 === 1'b0);
        while (valid256 !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
            if (valid256 !== 1'b1) begin
                if (idx256 !== ((k < 64) ? 7'(k) : 7'd0)) sweep_ok = 1'b0;
                if (ready256 !== 1'b0) ready_ok = 1'b0;
            end
        end
        start256 = 1'b0;
        dig = hash256;
        chk({tag, " latency"}, 512'(k), 512'd65);
        chk({tag, " idx sweep"}, 512'(sweep_ok), 512'd1);
        chk({tag, " busy"}, 512'(ready_ok), 512'd1);
        chk({tag, " ready at done"}, 512'(ready256), 512'd1);
        chk({tag, " digest"}, {256'd0, hash256}, ref_compress(32, {256'd0, h}, {512'd0, m}));
    endtask

    task automatic run512(input string tag, input logic [511:0] h, input logic [1023:0] m,
                          output logic [511:0] dig);
        int k;
        bit sweep_ok;
        h512 = h; m512 = m; start512 = 1'b1;
        @(negedge clk);
        start512 = 1'b0;
        k = 0;
        sweep_ok = (idx512 === 7'd0);
        while (valid512 !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
            if (valid512 !== 1'b1 && idx512 !== ((k < 80) ? 7'(k) : 7'd0)) sweep_ok = 1'b0;
        end
        dig = hash512;
        chk({tag, " latency"}, 512'(k), 512'd81);
        chk({tag, " idx sweep"}, 512'(sweep_ok), 512'd1);
        chk({tag, " digest"}, hash512, ref_compress(64, h, m));
    endtask

    initial begin
        logic [255:0]  d1, d2, hr;
        logic [511:0]  mr, d512, hr512;
        logic [1023:0] mr512;
        int            vbase, k;
        bit            stable_ok, valid_ok, idx_ok;

        reset = 1'b1;
        start256 = 1'b0; h256 = '0; m256 = '0;
        start512 = 1'b0; h512 = '0; m512 = '0;
        repeat (3) @(negedge clk);
        chk("reset hash256", {256'd0, hash256}, 512'd0);
        chk("reset valid256", 512'(valid256), 512'd0);
        chk("reset ready256", 512'(ready256), 512'd1);
        chk("reset idx256", 512'(idx256), 512'd0);
        chk("reset hash512", hash512, 512'd0);
        chk("reset ready512", 512'(ready512), 512'd1);
        reset = 1'b0;
        @(negedge clk);

        // SHA-256 "abc", then a back-to-back block chained on its digest with start held.
        vbase = vcnt256;
        run256("t1 abc", IV256, MSG256_ABC, 1'b0, d1);
        chk("t1 abc kat", {256'd0, d1}, {256'd0, DIG256_ABC});
        for (int i = 0; i < 16; i++) mr[i*32 +: 32] = $urandom;
        run256("t4 b2b", d1, mr, 1'b1, d2);
        @(negedge clk);
        chk("t4 pulse count", 512'(vcnt256 - vbase), 512'd2);

        // Idle hold after completion.
        stable_ok = 1'b1; valid_ok = 1'b1; idx_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (hash256 !== d2) stable_ok = 1'b0;
            if (valid256 !== 1'b0) valid_ok = 1'b0;
            if (idx256 !== 7'd0) idx_ok = 1'b0;
        end
        chk("t6 hash stable", 512'(stable_ok), 512'd1);
        chk("t6 valid low", 512'(valid_ok), 512'd1);
        chk("t6 idx zero", 512'(idx_ok), 512'd1);

        run256("t2 empty", IV256, MSG256_EMPTY, 1'b0, d1);
        chk("t2 empty kat", {256'd0, d1}, {256'd0, DIG256_EMPTY});
        @(negedge clk);

        for (int n = 0; n < 3; n++) begin
            for (int i = 0; i < 8; i++) hr[i*32 +: 32] = $urandom;
            for (int i = 0; i < 16; i++) mr[i*32 +: 32] = $urandom;
            run256("rand256", hr, mr, 1'b0, d1);
            @(negedge clk);
        end

        vbase = vcnt512;
        run512("t3 abc512", IV512, MSG512_ABC, d512);
        chk("t3 abc512 kat", d512, DIG512_ABC);
        @(negedge clk);
        for (int n = 0; n < 2; n++) begin
            for (int i = 0; i < 16; i++) hr512[i*32 +: 32] = $urandom;
            for (int i = 0; i < 32; i++) mr512[i*32 +: 32] = $urandom;
            run512("rand512", hr512, mr512, d512);
            @(negedge clk);
        end
        chk("t3 pulse count512", 512'(vcnt512 - vbase), 512'd3);

        // Abort a SHA-256 block at round 30 with an asynchronous reset.
        h256 = IV256; m256 = MSG256_ABC; start256 = 1'b1;
        @(negedge clk);
        start256 = 1'b0;
        k = 0;
        while (idx256 !== 7'd30 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("t5 reached round 30", 512'(idx256), 512'd30);
        vbase = vcnt256;
        reset = 1'b1;
        #1;
        chk("t5 reset hash", {256'd0, hash256}, 512'd0);
        chk("t5 reset valid", 512'(valid256), 512'd0);
        chk("t5 reset ready", 512'(ready256), 512'd1);
        chk("t5 reset idx", 512'(idx256), 512'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("t5 no late valid", 512'(vcnt256 - vbase), 512'd0);
        run256("t5 rerun", IV256, MSG256_ABC, 1'b0, d1);
        chk("t5 rerun kat", {256'd0, d1}, {256'd0, DIG256_ABC});
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
